// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush control: load-use bubble plus multi-cycle off-chip data memory handshake.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/bubble cycle counters.
module hazard_stall_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RTaddr_i,
  input  logic [4:0]  IFID_RSaddr_i,
  input  logic [4:0]  IFID_RTaddr_i,
  input  logic        EXMEM_MemRead_i,
  input  logic        EXMEM_MemWrite_i,
  input  logic [31:0] EXMEM_addr_i,
  input  logic [31:0] EXMEM_wdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] rdata_o,
  output logic        PC_stall_o,
  output logic        IFID_stall_o,
  output logic        IDEX_stall_o,
  output logic        EXMEM_stall_o,
  output logic        IDEX_flush_o,
  output logic        err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_bubble_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic acc;
  logic timeout_hit;
  logic memstall;
  logic luh;

  assign acc         = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == T_LAST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d = S_WAIT;
          timer_d = '0;
          req_d   = 1'b1;
          we_d    = EXMEM_MemWrite_i;
          addr_d  = EXMEM_addr_i;
          wdata_d = EXMEM_wdata_i;
        end
      end
      S_WAIT: begin
        // A real ack always beats a coincident timeout.
        if (mem_ack_i) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = mem_rdata_i;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rdata_d = 32'hDEADBEEF;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign memstall = ((state_q == S_IDLE) && acc) || (state_q == S_WAIT);
  assign luh = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) &&
               ((IDEX_RTaddr_i == IFID_RSaddr_i) || (IDEX_RTaddr_i == IFID_RTaddr_i));

  // Memory freeze dominates: a bubble inserted while the whole pipe is held would be lost.
  always_comb begin
    PC_stall_o    = 1'b0;
    IFID_stall_o  = 1'b0;
    IDEX_stall_o  = 1'b0;
    EXMEM_stall_o = 1'b0;
    IDEX_flush_o  = 1'b0;
    if (memstall) begin
      PC_stall_o    = 1'b1;
      IFID_stall_o  = 1'b1;
      IDEX_stall_o  = 1'b1;
      EXMEM_stall_o = 1'b1;
    end else if (luh) begin
      PC_stall_o   = 1'b1;
      IFID_stall_o = 1'b1;
      IDEX_flush_o = 1'b1;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_bubble_d = perf_bubble_q;
    if (memstall && (perf_stall_q != 32'hFFFFFFFF))
      perf_stall_d = perf_stall_q + 32'd1;
    if (IDEX_flush_o && (perf_bubble_q != 32'hFFFFFFFF))
      perf_bubble_d = perf_bubble_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_stall_o  = perf_stall_q;
  assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use vector table plus memory handshake sequences.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i;
  logic        EXMEM_MemRead_i, EXMEM_MemWrite_i;
  logic [31:0] EXMEM_addr_i, EXMEM_wdata_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
  logic        PC_stall_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o, IDEX_flush_o, err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_o, perf_bubble_o;
`endif

  logic [4:0] ctl;
  assign ctl = {PC_stall_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o, IDEX_flush_o};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.TIMEOUT_CYC(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .IDEX_MemRead_i  (IDEX_MemRead_i),
    .IDEX_RTaddr_i   (IDEX_RTaddr_i),
    .IFID_RSaddr_i   (IFID_RSaddr_i),
    .IFID_RTaddr_i   (IFID_RTaddr_i),
    .EXMEM_MemRead_i (EXMEM_MemRead_i),
    .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
    .EXMEM_addr_i    (EXMEM_addr_i),
    .EXMEM_wdata_i   (EXMEM_wdata_i),
    .mem_ack_i       (mem_ack_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .rdata_o         (rdata_o),
    .PC_stall_o      (PC_stall_o),
    .IFID_stall_o    (IFID_stall_o),
    .IDEX_stall_o    (IDEX_stall_o),
    .EXMEM_stall_o   (EXMEM_stall_o),
    .IDEX_flush_o    (IDEX_flush_o),
    .err_o           (err_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_o    (perf_stall_o),
    .perf_bubble_o   (perf_bubble_o)
`endif
  );

  typedef struct {
    logic       rd;
    logic [4:0] rt;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic [4:0] exp;   // {pc, ifid, idex, exmem, flush}
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One MEM access; ack arrives dly cycles after req becomes visible.
  task automatic run_access(input logic is_wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int dly, output int stalls);
    stalls = 0;
    for (int c = 0; c <= dly + 2; c++) begin
      @(negedge clk);
      if (c == 0) begin
        EXMEM_MemRead_i  = !is_wr;
        EXMEM_MemWrite_i = is_wr;
        EXMEM_addr_i     = addr;
        EXMEM_wdata_i    = wd;
      end
      mem_ack_i   = (c == dly + 1);
      mem_rdata_i = (c == dly + 1) ? rd : 32'h0;
      if (c == dly + 2) begin
        EXMEM_MemRead_i  = 1'b0;
        EXMEM_MemWrite_i = 1'b0;
      end
      #1;
      if (PC_stall_o) stalls++;
      if (c == 1) begin
        chk("acc_req", {31'd0, mem_req_o}, 32'd1);
        chk("acc_we", {31'd0, mem_we_o}, {31'd0, is_wr});
        chk("acc_addr", mem_addr_o, addr);
        if (is_wr) chk("acc_wdata", mem_wdata_o, wd);
      end
      if (c == dly + 2) begin
        chk("acc_req_drop", {31'd0, mem_req_o}, 32'd0);
        chk("acc_done_ctl", {27'd0, ctl}, 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd3,  5'b11001};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd0,  5'b00000};
    vecs[2] = '{1'b0, 5'd5,  5'd5,  5'd5,  5'b00000};
    vecs[3] = '{1'b1, 5'd7,  5'd1,  5'd7,  5'b11001};
    vecs[4] = '{1'b1, 5'd7,  5'd1,  5'd2,  5'b00000};
    vecs[5] = '{1'b1, 5'd31, 5'd31, 5'd31, 5'b11001};

    rst_i = 1'b1;
    IDEX_MemRead_i = 0; IDEX_RTaddr_i = 0; IFID_RSaddr_i = 0; IFID_RTaddr_i = 0;
    EXMEM_MemRead_i = 0; EXMEM_MemWrite_i = 0; EXMEM_addr_i = 0; EXMEM_wdata_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_ctl", {27'd0, ctl}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      IDEX_MemRead_i = vecs[i].rd;
      IDEX_RTaddr_i  = vecs[i].rt;
      IFID_RSaddr_i  = vecs[i].rs_id;
      IFID_RTaddr_i  = vecs[i].rt_id;
      #1;
      chk($sformatf("lu_vec%0d", i), {27'd0, ctl}, {27'd0, vecs[i].exp});
    end

    // Bubble lasts one cycle: ID_EX then holds a non-load.
    @(negedge clk);
    IDEX_MemRead_i = 1; IDEX_RTaddr_i = 5; IFID_RSaddr_i = 5; IFID_RTaddr_i = 0;
    #1 chk("lu_bubble", {27'd0, ctl}, 32'b11001);
    @(negedge clk);
    IDEX_MemRead_i = 0;
    #1 chk("lu_after", {27'd0, ctl}, 32'd0);
    IDEX_RTaddr_i = 0; IFID_RSaddr_i = 0;

    run_access(1'b0, 32'h40, 32'h0, 32'h1234, 3, st);
    chk("load_stalls", st, 32'd5);
    chk("load_rdata", rdata_o, 32'h1234);

    run_access(1'b1, 32'h80, 32'hA5A5A5A5, 32'h5555AAAA, 0, st);
    chk("store_stalls", st, 32'd2);
    chk("store_rdata_kept", rdata_o, 32'h1234);

    // Load-use and MEM access together.
    @(negedge clk);
    IDEX_MemRead_i = 1; IDEX_RTaddr_i = 5; IFID_RSaddr_i = 5;
    EXMEM_MemRead_i = 1; EXMEM_addr_i = 32'h44;
    #1 chk("both_idle", {27'd0, ctl}, 32'b11110);
    @(negedge clk);
    mem_ack_i = 1; mem_rdata_i = 32'h77;
    #1 chk("both_wait", {27'd0, ctl}, 32'b11110);
    @(negedge clk);
    mem_ack_i = 0; mem_rdata_i = 0; EXMEM_MemRead_i = 0;
    #1 chk("both_release", {27'd0, ctl}, 32'b11001);
    @(negedge clk);
    IDEX_MemRead_i = 0;
    #1 chk("both_clear", {27'd0, ctl}, 32'd0);
    chk("both_rdata", rdata_o, 32'h77);
    IDEX_RTaddr_i = 0; IFID_RSaddr_i = 0;

    // Stray ack while idle.
    @(negedge clk);
    mem_ack_i = 1; mem_rdata_i = 32'hFFFF;
    #1 chk("idle_ack_ctl", {27'd0, ctl}, 32'd0);
    @(negedge clk);
    mem_ack_i = 0; mem_rdata_i = 0;
    #1;
    chk("idle_ack_req", {31'd0, mem_req_o}, 32'd0);
    chk("idle_ack_rdata", rdata_o, 32'h77);

    // Timeout: no ack ever.
    @(negedge clk);
    EXMEM_MemRead_i = 1; EXMEM_addr_i = 32'h100;
    #1 chk("to_c0", {31'd0, PC_stall_o}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1 chk($sformatf("to_wait%0d", c), {31'd0, PC_stall_o}, 32'd1);
    end
    @(negedge clk);
    EXMEM_MemRead_i = 0;
    #1;
    chk("to_done_ctl", {27'd0, ctl}, 32'd0);
    chk("to_err", {31'd0, err_o}, 32'd1);
    chk("to_rdata", rdata_o, 32'hDEADBEEF);
    chk("to_req", {31'd0, mem_req_o}, 32'd0);
    repeat (2) @(negedge clk);
    #1 chk("to_err_sticky", {31'd0, err_o}, 32'd1);

    // Reset during WAIT.
    @(negedge clk);
    EXMEM_MemRead_i = 1; EXMEM_addr_i = 32'h200;
    @(negedge clk);
    #1 chk("rw_req", {31'd0, mem_req_o}, 32'd1);
    @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0; EXMEM_MemRead_i = 0;
    #1;
    chk("rw_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("rw_err_clr", {31'd0, err_o}, 32'd0);
    chk("rw_ctl", {27'd0, ctl}, 32'd0);
    chk("rw_rdata", rdata_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
